// File: rtl/fat_chain_sector_writer_if.sv
// Request and byte-stream bus between a FAT sector generator and its sink.
// The master requests sectors and accepts bytes; the slave produces them.
interface fat_chain_sector_writer_if;
  logic        Start;
  logic [31:0] SectorIndex;
  logic [31:0] FirstCluster;
  logic [31:0] ClusterCount;
  logic [31:0] RootClusterNumber;
  logic        ByteValid;
  logic        ByteReady;
  logic [8:0]  WriteAddress;
  logic [7:0]  Byte;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start, SectorIndex, FirstCluster, ClusterCount, RootClusterNumber, ByteReady,
    input  ByteValid, WriteAddress, Byte, Busy, Done, Error
  );

  modport slave (
    input  Start, SectorIndex, FirstCluster, ClusterCount, RootClusterNumber, ByteReady,
    output ByteValid, WriteAddress, Byte, Busy, Done, Error
  );
endinterface

// File: rtl/fat_chain_sector_writer.sv
// Generates one 512-byte FAT32 sector describing a single contiguous cluster chain,
// streamed little-endian over a valid/ready byte interface.
module fat_chain_sector_writer #(
  parameter logic [31:0] ClusterEOC = 32'h0FFFFFFF,
  parameter logic [31:0] MediaEntry = 32'h0FFFFFF8
) (
  input logic                     Clock,
  input logic                     sys_rst_n,
  fat_chain_sector_writer_if.slave bus
);

  localparam int unsigned AddrW  = 9;
  localparam int unsigned DataW  = 32;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned GW     = 39;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(511);
  localparam logic [DataW:0]   MaxLast  = 33'h0_0FFF_FFEF;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   sector_q, sector_d;
  logic [DataW-1:0]   first_q, first_d;
  logic [DataW-1:0]   count_q, count_d;
  logic [DataW-1:0]   root_q, root_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;
  logic [DataW:0]     last_c;
  logic               reject_c;

  // Byte of the FAT entry at a sector offset; g is kept at full width so large sectors never alias.
  function automatic logic [ByteW-1:0] entry_byte(input logic [AddrW-1:0] addr,
                                                   input logic [DataW-1:0] sector,
                                                   input logic [DataW-1:0] first,
                                                   input logic [DataW-1:0] root,
                                                   input logic [DataW:0]   last);
    logic [GW-1:0]    g;
    logic [DataW-1:0] entry;
    g = {sector, 7'd0} + GW'(addr[AddrW-1:2]);
    if (g == GW'(0))                                 entry = MediaEntry;
    else if (g == GW'(1))                            entry = ClusterEOC;
    else if (g == GW'(root))                         entry = ClusterEOC;
    else if (g >= GW'(first) && g < GW'(last))       entry = DataW'(g + GW'(1));
    else if (g == GW'(last))                         entry = ClusterEOC;
    else                                             entry = '0;
    return entry[{addr[1:0], 3'b000} +: ByteW];
  endfunction

  assign last_c   = 33'(first_q) + 33'(count_q) - 33'd1;
  assign reject_c = (count_q == '0) || (first_q < 32'd2) || (last_c > MaxLast) ||
                    ((33'(root_q) >= 33'(first_q)) && (33'(root_q) <= last_c));

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      sector_q <= '0;
      first_q  <= '0;
      count_q  <= '0;
      root_q   <= '0;
      addr_q   <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      first_q  <= first_d;
      count_q  <= count_d;
      root_q   <= root_d;
      addr_q   <= addr_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    first_d  = first_q;
    count_d  = count_q;
    root_d   = root_q;
    addr_d   = addr_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          sector_d = bus.SectorIndex;
          first_d  = bus.FirstCluster;
          count_d  = bus.ClusterCount;
          root_d   = bus.RootClusterNumber;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (reject_c) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = '0;
          byte_d  = entry_byte('0, sector_q, first_q, root_q, last_c);
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Next byte is precomputed on each transfer so Byte stays a pure register.
        if (valid_q && bus.ByteReady) begin
          if (addr_q == LastAddr) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            addr_d = addr_q + AddrW'(1);
            byte_d = entry_byte(addr_d, sector_q, first_q, root_q, last_c);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.ByteValid    = valid_q;
  assign bus.WriteAddress = addr_q;
  assign bus.Byte         = byte_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Error        = error_q;

endmodule
